// File: rtl/ysyx_24100005_ifu.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24100005_ifu
//  Description : Instruction fetch unit for the single-cycle RV32 core. Owns
//                the architectural PC and issues one instruction-memory read
//                per instruction over valid/ready request/response channels.
//                The fetched word and its PC are presented to execute, then
//                the unit waits for execute to commit the next PC (dnpc)
//                before fetching again.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst                    clock; asynchronous active-low reset
//    imem_req_valid/ready/addr   fetch request channel (addr is always pc)
//    imem_rsp_valid/ready        fetch response channel handshake
//    imem_rsp_data/err           instruction word and access-fault flag
//    inst_valid/ready            instruction hand-off to execute
//    inst, pc, inst_fault        delivered instruction, its PC, fault flag
//    commit_valid, commit_dnpc   next PC committed by execute
//    fetch_cnt                   instructions delivered to execute (wraps)
// ============================================================================
module ysyx_24100005_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  output logic        imem_rsp_ready,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_fault,
  input  logic        commit_valid,
  input  logic [31:0] commit_dnpc,
  output logic [31:0] fetch_cnt
);

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_EXEC = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_inst_fault;
  logic [31:0] r_fetch_cnt;
  logic        w_misaligned;

  // A dnpc that is not word aligned can never be fetched; it is turned into
  // a faulting nop without touching memory.
  assign w_misaligned = (commit_dnpc[1:0] != 2'b00);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and handshake outputs (Moore: depend on state only)
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    imem_req_valid = 1'b0;
    imem_rsp_ready = 1'b0;
    inst_valid     = 1'b0;
    case (r_state)
      S_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        imem_rsp_ready = 1'b1;
        if (imem_rsp_valid) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (commit_valid) w_state_nxt = w_misaligned ? S_HOLD : S_REQ;
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc         <= RESET_PC;
      r_inst       <= 32'h0;
      r_inst_fault <= 1'b0;
      r_fetch_cnt  <= 32'h0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (imem_rsp_valid) begin
            r_inst       <= imem_rsp_data;
            r_inst_fault <= imem_rsp_err;
          end
        end
        S_HOLD: begin
          if (inst_ready) r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
        S_EXEC: begin
          if (commit_valid) begin
            r_pc <= commit_dnpc;
            if (w_misaligned) begin
              r_inst       <= C_NOP;
              r_inst_fault <= 1'b1;
            end else begin
              r_inst_fault <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_req_addr = r_pc;
  assign pc            = r_pc;
  assign inst          = r_inst;
  assign inst_fault    = r_inst_fault;
  assign fetch_cnt     = r_fetch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100005_ifu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_24100005_ifu
//  Description : Self-checking bench for ysyx_24100005_ifu. A transaction-level
//                model tracks which handshake the fetch unit should offer next
//                and the PC/instruction/fault/count it should present; random
//                memory, execute and commit behaviour drives it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_24100005_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_fault;
  logic        commit_valid;
  logic [31:0] commit_dnpc;
  logic [31:0] fetch_cnt;

  always #5 clk = ~clk;

  ysyx_24100005_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_ready (imem_rsp_ready),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .pc             (pc),
    .inst_fault     (inst_fault),
    .commit_valid   (commit_valid),
    .commit_dnpc    (commit_dnpc),
    .fetch_cnt      (fetch_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level view: which hand-off is outstanding.
  typedef enum {M_FETCH, M_PEND, M_DELIV, M_EXEC} mphase_t;
  mphase_t     m_phase;
  logic [31:0] m_pc, m_inst, m_cnt;
  logic        m_fault;
  int unsigned m_wait, m_exec_wait;

  // Stimulus knobs (percentages / cycle ranges)
  int unsigned p_req, p_inst, p_mis, p_junk;
  int unsigned rsp_lo, rsp_hi, exec_hi;
  logic        err_en;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    if (a == RESET_PC) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] new_pc();
    logic [31:0] p;
    p = RESET_PC + ({22'd0, 10'($urandom_range(0, 255))} << 2);
    if ($urandom_range(0, 99) < p_mis) p = p + 32'($urandom_range(1, 3));
    return p;
  endfunction

  task automatic model_reset();
    m_phase = M_FETCH;
    m_pc    = RESET_PC;
    m_inst  = 32'h0;
    m_fault = 1'b0;
    m_cnt   = 32'h0;
  endtask

  // One clock: advance the model by the handshakes that completed at the last
  // rising edge, compare every output, then drive inputs for the next edge.
  task automatic step();
    @(negedge clk);
    if (rst) begin
      case (m_phase)
        M_FETCH: if (imem_req_ready) begin
          m_phase = M_PEND;
          m_wait  = $urandom_range(rsp_lo, rsp_hi);
        end
        M_PEND: if (imem_rsp_valid) begin
          m_phase = M_DELIV;
          m_inst  = imem_rsp_data;
          m_fault = imem_rsp_err;
        end
        M_DELIV: if (inst_ready) begin
          m_cnt       = m_cnt + 32'd1;
          m_phase     = M_EXEC;
          m_exec_wait = $urandom_range(0, exec_hi);
        end
        M_EXEC: if (commit_valid) begin
          m_pc = commit_dnpc;
          if (commit_dnpc % 4 != 0) begin
            m_inst  = NOP;
            m_fault = 1'b1;
            m_phase = M_DELIV;
          end else begin
            m_fault = 1'b0;
            m_phase = M_FETCH;
          end
        end
        default: ;
      endcase
    end

    check("req_valid",  32'(imem_req_valid), 32'(m_phase == M_FETCH));
    check("rsp_ready",  32'(imem_rsp_ready), 32'(m_phase == M_PEND));
    check("inst_valid", 32'(inst_valid),     32'(m_phase == M_DELIV));
    check("req_addr",   imem_req_addr,       m_pc);
    check("pc",         pc,                  m_pc);
    check("inst",       inst,                m_inst);
    check("inst_fault", 32'(inst_fault),     32'(m_fault));
    check("fetch_cnt",  fetch_cnt,           m_cnt);

    imem_req_ready = ($urandom_range(0, 99) < p_req);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    imem_rsp_err   = 1'($urandom_range(0, 1));
    if (m_phase == M_PEND) begin
      if (m_wait == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memdata(m_pc);
        imem_rsp_err   = err_en && ($urandom_range(0, 3) == 0);
      end else begin
        m_wait--;
      end
    end
    inst_ready = ($urandom_range(0, 99) < p_inst);
    if (m_phase == M_EXEC) begin
      if (m_exec_wait == 0) begin
        commit_valid = 1'b1;
        commit_dnpc  = new_pc();
      end else begin
        m_exec_wait--;
        commit_valid = 1'b0;
        commit_dnpc  = $urandom;
      end
    end else begin
      commit_valid = ($urandom_range(0, 99) < p_junk);
      commit_dnpc  = $urandom;
    end
  endtask

  initial begin
    int n;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_rsp_err   = 1'b0;
    inst_ready     = 1'b0;
    commit_valid   = 1'b0;
    commit_dnpc    = 32'h0;
    p_req = 100; p_inst = 100; p_mis = 0; p_junk = 0;
    rsp_lo = 0; rsp_hi = 0; exec_hi = 0; err_en = 1'b0;
    model_reset();

    // Reset values, then full-speed fetches (4-cycle period, 3rd-cycle hand-off)
    repeat (2) step();
    rst = 1'b1;
    repeat (12) step();

    // Request back-pressure for 5 cycles, address must hold
    p_req = 0;
    repeat (5) step();
    p_req = 100;
    repeat (8) step();

    // Slow memory (3 wait cycles) and execute stalls
    rsp_lo = 3; rsp_hi = 3; p_inst = 20;
    repeat (40) step();

    // Fully random: misaligned commits, access faults, stray commit pulses
    rsp_lo = 0; rsp_hi = 3; exec_hi = 2;
    p_req = 60; p_inst = 60; p_mis = 30; p_junk = 25; err_en = 1'b1;
    repeat (500) step();

    // Asynchronous reset while a memory read is outstanding
    n = 0;
    while (m_phase != M_PEND && n < 100) begin step(); n++; end
    check("reach_wait", 32'(m_phase == M_PEND), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_pc",        pc,                      RESET_PC);
    check("rst_fetch_cnt", fetch_cnt,               32'h0);
    check("rst_req_valid", 32'(imem_req_valid),     32'd1);
    check("rst_rsp_ready", 32'(imem_rsp_ready),     32'd0);
    model_reset();
    step();
    rst = 1'b1;
    repeat (100) step();

    // Counter wrap
    n = 0;
    while (m_phase != M_FETCH && n < 100) begin step(); n++; end
    check("reach_fetch", 32'(m_phase == M_FETCH), 32'd1);
    force dut.r_fetch_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_fetch_cnt;
    m_cnt = 32'hFFFF_FFFF;
    n = 0;
    while (m_cnt != 32'h0 && n < 300) begin step(); n++; end
    check("cnt_wrap", fetch_cnt, 32'h0);
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
